// File: rtl/epu_buf_pkg.sv
// Shared definitions for the EPU weight-buffer family: host FSM states,
// write-enable levels and default field widths.
package epu_buf_pkg;

  localparam int unsigned NUM_BANKS = 2;
  localparam int unsigned LEN_W_DEF = 8;

  localparam logic WRITE_ENB = 1'b1;
  localparam logic WRITE_DIS = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DATA,
    ST_WR_DATA
  } host_state_t;

endpackage

// File: rtl/wbuf_bank.sv
// Behavioural single-port SRAM bank with byte write enables and a
// registered read port; the read register holds while the bank is idle.
module wbuf_bank
  import epu_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 18432,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic [DATA_W/8-1:0] we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (cs) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (we[b] == WRITE_ENB) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (cs && (we == '0)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wbuf_pingpong.sv
// Double-buffered weight store: EPU owns the active bank, the host burst
// port owns the shadow bank, and a deferred swap exchanges them.
module wbuf_pingpong
  import epu_buf_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BANK_DEPTH = 18432,
  parameter int unsigned AW         = $clog2(BANK_DEPTH),
  parameter int unsigned LEN_W      = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                h_ar_valid,
  output logic                h_ar_ready,
  input  logic [31:0]         h_ar_addr,
  input  logic [LEN_W-1:0]    h_ar_len,
  output logic                h_r_valid,
  input  logic                h_r_ready,
  output logic [DATA_W-1:0]   h_r_data,
  output logic                h_r_last,
  input  logic                h_aw_valid,
  output logic                h_aw_ready,
  input  logic [31:0]         h_aw_addr,
  input  logic [LEN_W-1:0]    h_aw_len,
  input  logic                h_w_valid,
  output logic                h_w_ready,
  input  logic [DATA_W-1:0]   h_w_data,
  input  logic [DATA_W/8-1:0] h_w_strb,
  input  logic                e_start,
  input  logic                e_finish,
  input  logic                e_cs,
  input  logic [DATA_W/8-1:0] e_we,
  input  logic [AW-1:0]       e_addr,
  input  logic [DATA_W-1:0]   e_wdata,
  output logic [DATA_W-1:0]   e_rdata,
  input  logic                swap_i,
  output logic                active_o,
  output logic                swap_pend_o,
  output logic                e_busy_o
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(BANK_DEPTH);

  host_state_t       state;
  logic [AW-1:0]     base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              ar_hs;
  logic              aw_hs;
  logic              swap_apply;
  logic              h_cs;
  logic [NB-1:0]     h_we;
  logic [AW-1:0]     h_addr;
  logic              e_cs_q;
  logic              e_sel_q;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
  logic              addr_unused;

  assign addr_unused = ^{h_ar_addr[31:AW+2], h_ar_addr[1:0],
                         h_aw_addr[31:AW+2], h_aw_addr[1:0]};

  // Any value below 2*BANK_DEPTH folds back into the bank with one subtract.
  function automatic logic [AW-1:0] wrap_off(input logic [AW:0] v);
    return (v >= DEPTH_W) ? AW'(v - DEPTH_W) : v[AW-1:0];
  endfunction

  assign h_ar_ready = (state == ST_IDLE) && !swap_pend_o;
  assign h_aw_ready = (state == ST_IDLE) && !swap_pend_o;
  assign ar_hs      = h_ar_ready && h_ar_valid;
  assign aw_hs      = h_aw_ready && h_aw_valid && !h_ar_valid;
  assign swap_apply = swap_pend_o && (state == ST_IDLE) && !ar_hs && !aw_hs
                      && !e_busy_o && !e_start;

  assign h_r_valid = (state == ST_RD_DATA);
  assign h_r_last  = (state == ST_RD_DATA) && (cnt_q == len_q);
  assign h_w_ready = (state == ST_WR_DATA);
  // Shadow bank is untouched while in RD_DATA, so its read register holds the beat.
  assign h_r_data  = (state == ST_RD_DATA) ? bank_rdata[~active_o] : '0;

  assign h_cs   = (state == ST_RD_ISSUE) || ((state == ST_WR_DATA) && h_w_valid);
  assign h_we   = (state == ST_WR_DATA) ? h_w_strb : {NB{WRITE_DIS}};
  assign h_addr = wrap_off({1'b0, base_q} + {{(AW+1-LEN_W){1'b0}}, cnt_q});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            base_q <= wrap_off({1'b0, h_ar_addr[AW+1:2]});
            len_q  <= h_ar_len;
            cnt_q  <= '0;
            state  <= ST_RD_ISSUE;
          end else if (aw_hs) begin
            base_q <= wrap_off({1'b0, h_aw_addr[AW+1:2]});
            len_q  <= h_aw_len;
            cnt_q  <= '0;
            state  <= ST_WR_DATA;
          end
        end
        ST_RD_ISSUE: state <= ST_RD_DATA;
        ST_RD_DATA: begin
          if (h_r_ready) begin
            if (cnt_q == len_q) begin
              state <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              state <= ST_RD_ISSUE;
            end
          end
        end
        ST_WR_DATA: begin
          if (h_w_valid) begin
            if (cnt_q == len_q) state <= ST_IDLE;
            else cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active_o    <= 1'b0;
      swap_pend_o <= 1'b0;
      e_busy_o    <= 1'b0;
      e_cs_q      <= 1'b0;
      e_sel_q     <= 1'b0;
    end else begin
      if (swap_apply) begin
        active_o    <= ~active_o;
        swap_pend_o <= 1'b0;
      end else if (swap_i) begin
        swap_pend_o <= 1'b1;
      end
      if (e_start) e_busy_o <= 1'b1;
      else if (e_finish) e_busy_o <= 1'b0;
      e_cs_q  <= e_cs;
      e_sel_q <= active_o;
    end
  end

  // Remember which bank the EPU addressed so a swap cannot redirect its read data.
  assign e_rdata = e_cs_q ? bank_rdata[e_sel_q] : '0;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic e_own;
    assign e_own = (active_o == 1'(g));

    wbuf_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (BANK_DEPTH),
      .AW     (AW)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .cs    (e_own ? e_cs    : h_cs),
      .we    (e_own ? e_we    : h_we),
      .addr  (e_own ? e_addr  : h_addr),
      .wdata (e_own ? e_wdata : h_w_data),
      .rdata (bank_rdata[g])
    );
  end

endmodule
